// File: rtl/cpu32_wb_pkg.sv
// cpu32_wb_pkg: shared write-back definitions for the CPU32 pipeline.
//   - write-back opcode encodings
//   - 2-bit write-mask constants ({port2, port1})
//   - write-record layout at the default CPU32 widths (32-bit data, 5-bit addr)
package cpu32_wb_pkg;

  localparam logic [3:0] WB_NOP     = 4'd0;
  localparam logic [3:0] WB_R1_A1   = 4'd1;
  localparam logic [3:0] WB_R1_A2   = 4'd2;
  localparam logic [3:0] WB_R1_R2   = 4'd3;   // r1 -> r2[ADDR_W-1:0]
  localparam logic [3:0] WB_R2_A1   = 4'd4;
  localparam logic [3:0] WB_R2_A2   = 4'd5;
  localparam logic [3:0] WB_R2_R1   = 4'd6;   // r2 -> r1[ADDR_W-1:0]
  localparam logic [3:0] WB_DUAL    = 4'd7;   // {r1->a1, r2->a2}
  localparam logic [3:0] WB_SWAP    = 4'd8;   // {r1->a2, r2->a1}
  localparam logic [3:0] WB_ZERO_A1 = 4'd9;
  localparam logic [3:0] WB_ZERO_A2 = 4'd10;

  localparam logic [1:0] WB_MASK_NONE = 2'b00;
  localparam logic [1:0] WB_MASK_P1   = 2'b01;
  localparam logic [1:0] WB_MASK_P2   = 2'b10;
  localparam logic [1:0] WB_MASK_BOTH = 2'b11;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  // Write record at the default CPU32 widths. Parameterised instances of the
  // queue keep the same field order in a locally sized copy of this layout.
  typedef struct packed {
    logic [1:0]           mask;
    logic [WB_DATA_W-1:0] wr1;
    logic [WB_DATA_W-1:0] wr2;
    logic [WB_ADDR_W-1:0] wa1;
    logic [WB_ADDR_W-1:0] wa2;
  } wb_rec_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: generic synchronous FIFO of fixed-width records.
//   clk, rst (async, active-low)
//   push/din  : write din when not full
//   pop       : drop head when not empty
//   head      : storage at read pointer (registered, no bypass)
//   level     : occupied entries, 0..DEPTH
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [LVL_W-1:0] level
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PTR_W-1:0]            wr_ptr, rd_ptr;
  logic                        push_ok, pop_ok;

  assign push_ok = push && (level != LVL_W'(DEPTH));
  assign pop_ok  = pop  && (level != '0);
  assign head    = mem[rd_ptr];

  // Storage is reset so an empty queue presents all-zero record fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;   // DEPTH is a power of two: natural wrap
      end
      if (pop_ok)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/register_wb_queue.sv
// register_wb_queue: CPU32 write-back decode plus record queue.
//   clk, rst (async, active-low)
//   r1/r2, a1/a2, op, proceed : execute-side op; decoded into up to two writes
//   ready    : queue has room (level < DEPTH), depends on level only
//   rf_ready : register file consumes the head record this cycle
//   write, wr1/wr2, wa1/wa2 : head record; write=00 while empty
//   level    : occupied entries
//   overrun  : sticky, set when a non-empty op arrives while full
module register_wb_queue
  import cpu32_wb_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 4,
  parameter int ZERO_REG = 1,
  localparam int LVL_W   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] r1,
  input  logic [DATA_W-1:0] r2,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  input  logic [3:0]        op,
  input  logic              proceed,
  output logic              ready,
  input  logic              rf_ready,
  output logic [1:0]        write,
  output logic [DATA_W-1:0] wr1,
  output logic [DATA_W-1:0] wr2,
  output logic [ADDR_W-1:0] wa1,
  output logic [ADDR_W-1:0] wa2,
  output logic [LVL_W-1:0]  level,
  output logic              overrun
);

  // Same field order as wb_rec_t, sized by this instance's parameters.
  typedef struct packed {
    logic [1:0]        mask;
    logic [DATA_W-1:0] wr1;
    logic [DATA_W-1:0] wr2;
    logic [ADDR_W-1:0] wa1;
    logic [ADDR_W-1:0] wa2;
  } rec_t;

  rec_t rec, head;
  logic push, has_work;

  // Decode -> collapse -> R0 suppression. Collapse runs first so a dual op
  // aimed twice at R0 folds to one port and is then suppressed as a whole.
  always_comb begin
    rec = '0;
    case (op)
      WB_R1_A1:   begin rec.mask = WB_MASK_P1; rec.wr1 = r1;  rec.wa1 = a1; end
      WB_R1_A2:   begin rec.mask = WB_MASK_P1; rec.wr1 = r1;  rec.wa1 = a2; end
      WB_R1_R2:   begin rec.mask = WB_MASK_P1; rec.wr1 = r1;  rec.wa1 = r2[ADDR_W-1:0]; end
      WB_R2_A1:   begin rec.mask = WB_MASK_P1; rec.wr1 = r2;  rec.wa1 = a1; end
      WB_R2_A2:   begin rec.mask = WB_MASK_P1; rec.wr1 = r2;  rec.wa1 = a2; end
      WB_R2_R1:   begin rec.mask = WB_MASK_P1; rec.wr1 = r2;  rec.wa1 = r1[ADDR_W-1:0]; end
      WB_DUAL: begin
        rec.mask = WB_MASK_BOTH;
        rec.wr1  = r1; rec.wa1 = a1;
        rec.wr2  = r2; rec.wa2 = a2;
      end
      WB_SWAP: begin
        rec.mask = WB_MASK_BOTH;
        rec.wr1  = r1; rec.wa1 = a2;
        rec.wr2  = r2; rec.wa2 = a1;
      end
      WB_ZERO_A1: begin rec.mask = WB_MASK_P1; rec.wa1 = a1; end
      WB_ZERO_A2: begin rec.mask = WB_MASK_P1; rec.wa1 = a2; end
      default:    rec = '0;
    endcase

    // Both ports hitting one register: port 2 is the later write, so it wins.
    if (rec.mask == WB_MASK_BOTH && rec.wa1 == rec.wa2) begin
      rec.mask = WB_MASK_P1;
      rec.wr1  = rec.wr2;
      rec.wr2  = '0;
      rec.wa2  = '0;
    end

    if (ZERO_REG != 0) begin
      if (rec.wa1 == '0) rec.mask[0] = 1'b0;
      if (rec.wa2 == '0) rec.mask[1] = 1'b0;
    end
  end

  assign has_work = proceed && (rec.mask != WB_MASK_NONE);
  assign ready    = (level < LVL_W'(DEPTH));
  assign push     = has_work && ready;

  wb_fifo #(.DEPTH(DEPTH), .WIDTH($bits(rec_t))) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (rf_ready),
    .din   (rec),
    .head  (head),
    .level (level)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 overrun <= 1'b0;
    else if (has_work && !ready) overrun <= 1'b1;
  end

  assign write = (level != '0) ? head.mask : WB_MASK_NONE;
  assign wr1   = head.wr1;
  assign wr2   = head.wr2;
  assign wa1   = head.wa1;
  assign wa2   = head.wa2;

endmodule

// File: tb/tb_register_wb_queue.sv
// Directed bench for register_wb_queue (DATA_W=32, ADDR_W=5, DEPTH=4, ZERO_REG=1).
module tb_register_wb_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] r1, r2;
  logic [4:0]  a1, a2;
  logic [3:0]  op;
  logic        proceed, rf_ready;
  logic        ready, overrun;
  logic [1:0]  write;
  logic [31:0] wr1, wr2;
  logic [4:0]  wa1, wa2;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;

  register_wb_queue #(.DATA_W(32), .ADDR_W(5), .DEPTH(4), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .r1(r1), .r2(r2), .a1(a1), .a2(a2), .op(op),
    .proceed(proceed), .ready(ready), .rf_ready(rf_ready), .write(write),
    .wr1(wr1), .wr2(wr2), .wa1(wa1), .wa2(wa2), .level(level), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [4:0] x1, input logic [4:0] x2);
    op = o; r1 = v1; r2 = v2; a1 = x1; a2 = x2; proceed = 1'b1;
  endtask

  initial begin
    rst = 1'b0; r1 = '0; r2 = '0; a1 = '0; a2 = '0; op = '0;
    proceed = 1'b0; rf_ready = 1'b1;
    #12;
    chk("rst_write", write, 2'b00);
    chk("rst_level", level, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_ready", ready, 1);
    chk("rst_wr1", wr1, 0);
    tick();
    rst = 1'b1;
    tick();

    // single write, one-cycle latency, then drained
    drive(4'd1, 32'hDEADBEEF, 32'h0, 5'd3, 5'd0);
    tick(); proceed = 1'b0;
    chk("op1_write", write, 2'b01);
    chk("op1_wr1", wr1, 32'hDEADBEEF);
    chk("op1_wa1", wa1, 3);
    chk("op1_wr2", wr2, 0);
    tick();
    chk("op1_drain_write", write, 2'b00);
    chk("op1_drain_level", level, 0);

    // dual, same address: port 2 wins
    drive(4'd7, 32'h11, 32'h22, 5'd5, 5'd5);
    tick(); proceed = 1'b0;
    chk("coll_write", write, 2'b01);
    chk("coll_wa1", wa1, 5);
    chk("coll_wr1", wr1, 32'h22);
    chk("coll_wr2", wr2, 0);
    tick();

    // dual, distinct addresses
    drive(4'd7, 32'h33, 32'h44, 5'd1, 5'd2);
    tick(); proceed = 1'b0;
    chk("dual_write", write, 2'b11);
    chk("dual_wr1", wr1, 32'h33);
    chk("dual_wa1", wa1, 1);
    chk("dual_wr2", wr2, 32'h44);
    chk("dual_wa2", wa2, 2);
    tick();

    // swap with port 2 aimed at R0
    drive(4'd8, 32'hAA, 32'hBB, 5'd0, 5'd7);
    tick(); proceed = 1'b0;
    chk("r0_swap_write", write, 2'b01);
    chk("r0_swap_wa1", wa1, 7);
    chk("r0_swap_wr1", wr1, 32'hAA);
    tick();

    // fully suppressed single write and NOP opcode: nothing queued
    drive(4'd1, 32'h55, 32'h0, 5'd0, 5'd0);
    tick();
    chk("r0_only_level", level, 0);
    chk("r0_only_write", write, 2'b00);
    drive(4'd12, 32'h55, 32'h0, 5'd4, 5'd4);
    tick(); proceed = 1'b0;
    chk("nop12_level", level, 0);

    // fill under backpressure with assorted single-write opcodes
    rf_ready = 1'b0;
    drive(4'd2, 32'h100, 32'h0, 5'd0, 5'd9);        // r1 -> a2
    tick(); chk("fill1_level", level, 1);
    drive(4'd3, 32'h101, 32'h0000_0A0C, 5'd0, 5'd0); // r1 -> r2[4:0]=12
    tick(); chk("fill2_level", level, 2);
    drive(4'd6, 32'h13, 32'h202, 5'd0, 5'd0);       // r2 -> r1[4:0]=19
    tick(); chk("fill3_level", level, 3);
    drive(4'd10, 32'hFFFF, 32'hFFFF, 5'd0, 5'd4);   // 0 -> a2
    tick();
    chk("full_level", level, 4);
    chk("full_ready", ready, 0);
    chk("full_overrun_clear", overrun, 0);
    drive(4'd5, 32'h0, 32'h999, 5'd0, 5'd2);        // dropped
    tick(); proceed = 1'b0;
    chk("drop_overrun", overrun, 1);
    chk("drop_level", level, 4);
    chk("hold_wr1", wr1, 32'h100);

    rf_ready = 1'b1;
    #1;
    chk("full_rfready_ready", ready, 0);
    chk("drain0_wr1", wr1, 32'h100); chk("drain0_wa1", wa1, 9);
    tick();
    chk("drain1_wr1", wr1, 32'h101); chk("drain1_wa1", wa1, 12);
    tick();
    chk("drain2_wr1", wr1, 32'h202); chk("drain2_wa1", wa1, 19);
    tick();
    chk("drain3_wr1", wr1, 0); chk("drain3_wa1", wa1, 4);
    chk("drain3_write", write, 2'b01);
    tick();
    chk("drained_level", level, 0);
    chk("drained_write", write, 2'b00);
    chk("overrun_sticky", overrun, 1);

    // steady stream: push and pop every edge
    for (int i = 0; i < 6; i++) begin
      drive(4'd4, 32'h0, 32'h500 + i, 5'(i + 1), 5'd0);  // r2 -> a1
      tick();
      chk("stream_level", level, 1);
      chk("stream_wr1", wr1, 32'h500 + i);
      chk("stream_wa1", wa1, i + 1);
    end
    proceed = 1'b0;
    tick();
    chk("stream_end_level", level, 0);

    // reset mid-drain at level 3
    rf_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(4'd9, 32'h0, 32'h0, 5'(i + 20), 5'd0);
      tick();
    end
    proceed = 1'b0;
    drive(4'd1, 32'h77, 32'h0, 5'd6, 5'd0); proceed = 1'b0;
    chk("pre_rst_level", level, 3);
    rf_ready = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_level", level, 0);
    chk("async_rst_write", write, 2'b00);
    chk("async_rst_wa1", wa1, 0);
    chk("async_rst_overrun", overrun, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_level", level, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
